spi_draw_decoder: RTL and testbench
===================================

# spi_draw_decoder

Command decoder between the SPI byte receiver and the LED matrix `display` write port. It buffers received bytes in a small FIFO, parses them into draw commands (single pixel, clear, fill), and emits one-cycle framebuffer writes on the `write_en`/`write_x`/`write_y`/`pixel_color` interface that `pattern_generator` currently drives. It runs entirely in the `int_osc` domain. The upstream SPI peripheral delivers bytes already synchronized to that clock.

## Interface
- `FIFO_DEPTH`, 64, byte buffer entries; must be a power of 2, ≥4.
- `clk` input 1: system clock (`int_osc`).
- `resetn` input 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `rx_valid` input 1: one-cycle pulse; `rx_byte` is valid.
- `rx_byte` input 8: received byte.
- `rx_frame_end` input 1: one-cycle pulse on cs_n deassertion (end of SPI transaction).
- `write_en` output 1: framebuffer write strobe, one cycle per pixel.
- `write_x` output 6: column 0..63.
- `write_y` output 6: row 0..63.
- `pixel_color` output 12: {R[3:0],G[3:0],B[3:0]}.
- `busy` output 1: high while a CLEAR/FILL sweep is in progress.
- `overflow` output 1: sticky; a byte or frame marker was dropped because the FIFO was full.
- `bad_cmd` output 1: sticky; an undefined opcode was received.

## Operation
- FIFO entries are 9 bits, `{eof, data}`.
  - `rx_valid` pushes `{0, rx_byte}`.
  - `rx_frame_end` pushes marker `{1, 8'h00}`.
  - If `rx_valid` and `rx_frame_end` arrive in the same cycle, the byte is pushed that cycle and the marker is held in a pending flag, then pushed the next cycle.
- Push when full is dropped and sets `overflow`. Exception: a push and pop in the same cycle while full both succeed and set no flag.
- The parser pops at most one entry per cycle, only when the FIFO is non-empty and the state is not SWEEP.
- Opcodes (first byte of a packet):
  - 0x00 NOP: no payload.
  - 0x01 PIXEL: payload x, y, c_hi, c_lo. x and y use bits [5:0]; color is {c_hi[3:0], c_lo[7:0]}. Unused upper bits are ignored.
  - 0x02 CLEAR: no payload. Sweeps color 0x000.
  - 0x03 FILL: payload c_hi, c_lo. Sweeps that color.
  - Any other opcode: consumed, sets `bad_cmd`, state stays IDLE.
- States: IDLE, GET_X, GET_Y, GET_CHI, GET_CLO, SWEEP.
  - IDLE → GET_X on PIXEL; IDLE → SWEEP on CLEAR; IDLE → GET_CHI on FILL.
  - GET_X → GET_Y → GET_CHI → GET_CLO.
  - From GET_CLO: PIXEL emits one write and returns to IDLE. FILL enters SWEEP.
  - SWEEP → IDLE after writing (63,63).
- A marker popped in IDLE is a no-op. A marker popped in any GET_* state discards the partial packet (no write) and goes to IDLE.
- Sweep order is row-major, x inner: (0,0), (1,0) … (63,0), (0,1) … (63,63). That is 4096 consecutive `write_en` cycles with constant color.

## Timing
- All outputs are registered. Reset values: `write_en`=0, `write_x`=0, `write_y`=0, `pixel_color`=0, `busy`=0, `overflow`=0, `bad_cmd`=0. FIFO is empty, pending marker is cleared, state is IDLE.
- FIFO latency: a byte pushed at edge n is poppable at edge n+1 at the earliest.
- PIXEL: if c_lo is popped at edge k, `write_en`=1 with x/y/color valid during cycle k→k+1 only.
- Sweep: the sweep is entered at edge k (pop of the CLEAR opcode or the FILL c_lo).
  - `busy` and `write_en` are high from edge k until edge k+4096.
  - Both drop at edge k+4096.
  - The next pop is permitted at edge k+4096.
- Back-to-back PIXEL packets with bytes present give one write every 5 cycles.
- `overflow` and `bad_cmd` clear only on reset.
- Reset asserted mid-sweep or mid-packet clears all outputs immediately (asynchronously). FIFO contents are discarded.

## Structure
- Package `draw_pkg`:
  - opcode localparams `OP_NOP`, `OP_PIXEL`, `OP_CLEAR`, `OP_FILL`;
  - state enum `draw_state_t`;
  - `PANEL_W`=64, `COORD_W`=6, `COLOR_W`=12.
- Sub-module `byte_fifo`:
  - parameterized depth, 9-bit synchronous FIFO;
  - ports: push/pop/full/empty/count;
  - asynchronous active-low reset.
- The parser FSM and sweep counters (`write_x`/`write_y` reused as sweep counters) live in `spi_draw_decoder`.
- In `main`, `spi_draw_decoder` replaces `pattern_generator` as the driver of the `display` write port.

## Test plan
- **Single PIXEL:** push 01,05,0A,0F,3C → exactly one `write_en` at x=5, y=10, color=0xF3C, on the cycle after the c_lo pop. No other strobes.
- **Masking:** push 01,FF,C1,A7,00 → write x=63, y=1, color=0x700.
- **FILL sweep:** push 03,01,23 → 4096 consecutive `write_en` cycles with color 0x123. First write (0,0), last (63,63), 65th write (0,1). `busy` is high exactly during those cycles. PIXEL bytes pushed mid-sweep are written after `busy` falls.
- **Frame abort:** push 01,05, then `rx_frame_end`, then 01,02,03,00,FF → only write (2,3) with color 0x0FF. The coincident `rx_valid`+`rx_frame_end` case yields the same result.
- **Overflow:** with FIFO_DEPTH=64, push 02 then 70 more bytes during the sweep → `overflow`=1 and exactly 6 bytes dropped. Bytes accepted before full are processed in order.
- **Bad opcode and reset:** push 7E → `bad_cmd`=1, no write. Assert `resetn`=0 mid-CLEAR sweep → `write_en`, `busy`, `bad_cmd` go to 0 immediately. After release, the block is IDLE with the FIFO empty.

Source files
------------

// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : draw_pkg
//  Description : Shared types and constants for the SPI draw-command decoder:
//                opcodes, parser state encoding, panel geometry and the FIFO
//                entry format {eof, data}.
//  Revision    : 1.0 - initial release
// ============================================================================
package draw_pkg;

    localparam int PANEL_W = 64;
    localparam int COORD_W = 6;
    localparam int COLOR_W = 12;
    localparam int ENTRY_W = 9;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_PIXEL = 8'h01;
    localparam logic [7:0] OP_CLEAR = 8'h02;
    localparam logic [7:0] OP_FILL  = 8'h03;

    localparam logic [COORD_W-1:0] COORD_MAX  = COORD_W'(PANEL_W - 1);
    localparam logic [ENTRY_W-1:0] EOF_MARKER = {1'b1, 8'h00};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_X   = 3'd1,
        ST_GET_Y   = 3'd2,
        ST_GET_CHI = 3'd3,
        ST_GET_CLO = 3'd4,
        ST_SWEEP   = 3'd5
    } draw_state_t;

    function automatic logic [ENTRY_W-1:0] byte_entry(input logic [7:0] b);
        return {1'b0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_draw_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_draw_decoder_if
//  Description : Bundles the SPI byte-receiver side (rx_*) and the display
//                write port plus status flags of the draw decoder.
//                slave  : decoder view (consumes rx_*, drives write port/flags)
//                master : receiver/display view (drives rx_*, observes rest)
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_draw_decoder_if;
    import draw_pkg::*;

    logic               rx_valid;
    logic [7:0]         rx_byte;
    logic               rx_frame_end;
    logic               write_en;
    logic [COORD_W-1:0] write_x;
    logic [COORD_W-1:0] write_y;
    logic [COLOR_W-1:0] pixel_color;
    logic               busy;
    logic               overflow;
    logic               bad_cmd;

    modport slave (
        input  rx_valid, rx_byte, rx_frame_end,
        output write_en, write_x, write_y, pixel_color, busy, overflow, bad_cmd
    );

    modport master (
        output rx_valid, rx_byte, rx_frame_end,
        input  write_en, write_x, write_y, pixel_color, busy, overflow, bad_cmd
    );

endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous FIFO, DEPTH entries of WIDTH bits (power-of-2
//                depth). A push while full is dropped unless a pop happens in
//                the same cycle, in which case both succeed.
//  Ports       : clk, resetn (async active-low), push/push_data,
//                pop/pop_data (show-ahead), full, empty, count
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 9
) (
    input  wire logic                     clk,
    input  wire logic                     resetn,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         pop_data,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
    assign w_do_push = push && (!full || w_do_pop);

    // Storage carries no reset; pointer reset alone discards contents.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_draw_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_draw_decoder
//  Description : Buffers SPI bytes and frame-end markers in a FIFO, parses
//                NOP / PIXEL / CLEAR / FILL packets and drives one-cycle
//                framebuffer writes. CLEAR/FILL sweep all 64x64 pixels
//                row-major, reusing write_x/write_y as the sweep counters.
//  Ports       : clk, resetn (async active-low),
//                bus (slave): rx_valid, rx_byte, rx_frame_end -> write_en,
//                write_x, write_y, pixel_color, busy, overflow, bad_cmd
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_draw_decoder #(
    parameter int FIFO_DEPTH = 64
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    spi_draw_decoder_if.slave  bus
);
    import draw_pkg::*;

    // FIFO side
    logic                        r_pend;
    logic                        w_pend_n;
    logic                        w_push;
    logic [ENTRY_W-1:0]          w_push_data;
    logic                        w_pop;
    logic [ENTRY_W-1:0]          w_pop_data;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_unused_fifo_count;
    logic                        w_drop;

    // Parser
    draw_state_t                 r_state;
    draw_state_t                 w_state_n;
    draw_state_t                 w_parse_state;
    logic                        r_is_fill,  w_is_fill_n;
    logic [COORD_W-1:0]          r_px,       w_px_n;
    logic [COORD_W-1:0]          r_py,       w_py_n;
    logic [3:0]                  r_chi,      w_chi_n;
    logic                        w_sweep_last;
    logic                        w_entry_eof;
    logic [7:0]                  w_entry_byte;

    // Registered outputs
    logic                        r_write_en,  w_write_en_n;
    logic [COORD_W-1:0]          r_write_x,   w_write_x_n;
    logic [COORD_W-1:0]          r_write_y,   w_write_y_n;
    logic [COLOR_W-1:0]          r_color,     w_color_n;
    logic                        r_busy,      w_busy_n;
    logic                        r_overflow,  w_overflow_n;
    logic                        r_bad_cmd,   w_bad_cmd_n;

    // ------------------------------------------------------------------
    // Push arbitration. A marker coinciding with a byte is deferred one
    // cycle through r_pend. A byte arriving in that deferred cycle cannot be
    // stored (SPI byte timing makes this unreachable) and counts as dropped.
    // ------------------------------------------------------------------
    always_comb begin
        w_push      = r_pend || bus.rx_valid || bus.rx_frame_end;
        w_push_data = (r_pend || !bus.rx_valid) ? EOF_MARKER : byte_entry(bus.rx_byte);
        w_pend_n    = bus.rx_valid && bus.rx_frame_end && !r_pend;
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_unused_fifo_count)
    );

    assign w_drop = (w_push && w_fifo_full && !w_pop) || (r_pend && bus.rx_valid);

    // The final sweep cycle behaves like IDLE for the parser so the next
    // entry is consumed on the same edge the sweep ends.
    assign w_sweep_last  = (r_state == ST_SWEEP) && (r_write_x == COORD_MAX)
                           && (r_write_y == COORD_MAX);
    assign w_pop         = !w_fifo_empty && ((r_state != ST_SWEEP) || w_sweep_last);
    assign w_parse_state = w_sweep_last ? ST_IDLE : r_state;
    assign w_entry_eof   = w_pop_data[ENTRY_W-1];
    assign w_entry_byte  = w_pop_data[7:0];

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n    = r_state;
        w_is_fill_n  = r_is_fill;
        w_px_n       = r_px;
        w_py_n       = r_py;
        w_chi_n      = r_chi;
        w_write_en_n = 1'b0;
        w_write_x_n  = r_write_x;
        w_write_y_n  = r_write_y;
        w_color_n    = r_color;
        w_busy_n     = 1'b0;
        w_overflow_n = r_overflow || w_drop;
        w_bad_cmd_n  = r_bad_cmd;

        if (r_state == ST_SWEEP) begin
            if (w_sweep_last) begin
                w_state_n = ST_IDLE;
            end else begin
                w_write_en_n = 1'b1;
                w_busy_n     = 1'b1;
                w_write_x_n  = r_write_x + COORD_W'(1);
                if (r_write_x == COORD_MAX) begin
                    w_write_y_n = r_write_y + COORD_W'(1);
                end
            end
        end

        if (w_pop) begin
            if (w_entry_eof) begin
                // No-op in IDLE; abandons any partial packet elsewhere.
                w_state_n = ST_IDLE;
            end else begin
                case (w_parse_state)
                    ST_IDLE: begin
                        case (w_entry_byte)
                            OP_NOP: begin
                            end
                            OP_PIXEL: begin
                                w_is_fill_n = 1'b0;
                                w_state_n   = ST_GET_X;
                            end
                            OP_CLEAR: begin
                                w_state_n    = ST_SWEEP;
                                w_write_en_n = 1'b1;
                                w_busy_n     = 1'b1;
                                w_write_x_n  = '0;
                                w_write_y_n  = '0;
                                w_color_n    = '0;
                            end
                            OP_FILL: begin
                                w_is_fill_n = 1'b1;
                                w_state_n   = ST_GET_CHI;
                            end
                            default: begin
                                w_bad_cmd_n = 1'b1;
                            end
                        endcase
                    end
                    ST_GET_X: begin
                        w_px_n    = w_entry_byte[COORD_W-1:0];
                        w_state_n = ST_GET_Y;
                    end
                    ST_GET_Y: begin
                        w_py_n    = w_entry_byte[COORD_W-1:0];
                        w_state_n = ST_GET_CHI;
                    end
                    ST_GET_CHI: begin
                        w_chi_n   = w_entry_byte[3:0];
                        w_state_n = ST_GET_CLO;
                    end
                    ST_GET_CLO: begin
                        w_write_en_n = 1'b1;
                        w_color_n    = {r_chi, w_entry_byte};
                        if (r_is_fill) begin
                            w_state_n   = ST_SWEEP;
                            w_busy_n    = 1'b1;
                            w_write_x_n = '0;
                            w_write_y_n = '0;
                        end else begin
                            w_state_n   = ST_IDLE;
                            w_write_x_n = r_px;
                            w_write_y_n = r_py;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend     <= 1'b0;
            r_state    <= ST_IDLE;
            r_is_fill  <= 1'b0;
            r_px       <= '0;
            r_py       <= '0;
            r_chi      <= '0;
            r_write_en <= 1'b0;
            r_write_x  <= '0;
            r_write_y  <= '0;
            r_color    <= '0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_bad_cmd  <= 1'b0;
        end else begin
            r_pend     <= w_pend_n;
            r_state    <= w_state_n;
            r_is_fill  <= w_is_fill_n;
            r_px       <= w_px_n;
            r_py       <= w_py_n;
            r_chi      <= w_chi_n;
            r_write_en <= w_write_en_n;
            r_write_x  <= w_write_x_n;
            r_write_y  <= w_write_y_n;
            r_color    <= w_color_n;
            r_busy     <= w_busy_n;
            r_overflow <= w_overflow_n;
            r_bad_cmd  <= w_bad_cmd_n;
        end
    end

    assign bus.write_en    = r_write_en;
    assign bus.write_x     = r_write_x;
    assign bus.write_y     = r_write_y;
    assign bus.pixel_color = r_color;
    assign bus.busy        = r_busy;
    assign bus.overflow    = r_overflow;
    assign bus.bad_cmd     = r_bad_cmd;

endmodule
`default_nettype wire

// File: tb/tb_spi_draw_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_draw_decoder
//  Description : Scoreboard bench for spi_draw_decoder. Stimulus pushes the
//                expected writes into a queue; a monitor on the falling edge
//                pops and compares every write_en cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_draw_decoder;

    typedef struct packed {
        logic [5:0]  x;
        logic [5:0]  y;
        logic [11:0] c;
        logic        busy;
    } exp_t;

    logic clk;
    logic resetn;
    int   n_vec;
    int   n_miss;
    logic prev_we;
    exp_t sb[$];

    spi_draw_decoder_if bus();

    spi_draw_decoder #(
        .FIFO_DEPTH (64)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!resetn) begin
            prev_we = 1'b0;
        end else begin
            if (bus.busy && !bus.write_en) begin
                n_vec++;
                n_miss++;
                $display("FAIL busy_without_write: got busy=1 write_en=0 expected busy=0 (t=%0t)", $time);
            end
            if (bus.write_en) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_write: got x=%0d y=%0d c=0x%0h expected no write (t=%0t)",
                             bus.write_x, bus.write_y, bus.pixel_color, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("write{x,y,c,busy}",
                          {7'd0, bus.write_x, bus.write_y, bus.pixel_color, bus.busy}, {7'd0, e});
                    if (e.busy && ({e.x, e.y} != 12'd0)) begin
                        check("sweep_contiguous", {31'd0, prev_we}, 32'd1);
                    end
                end
            end
            prev_we = bus.write_en;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [7:0] b, input logic fe);
        @(posedge clk);
        #1;
        bus.rx_valid     = v;
        bus.rx_byte      = b;
        bus.rx_frame_end = fe;
        @(posedge clk);
        #1;
        bus.rx_valid     = 1'b0;
        bus.rx_frame_end = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0);
    endtask

    task automatic expect_pixel(input logic [5:0] x, input logic [5:0] y, input logic [11:0] c);
        sb.push_back({x, y, c, 1'b0});
    endtask

    task automatic expect_sweep(input logic [11:0] c);
        for (int yy = 0; yy < 64; yy++) begin
            for (int xx = 0; xx < 64; xx++) begin
                sb.push_back({6'(xx), 6'(yy), c, 1'b1});
            end
        end
    endtask

    task automatic send_pixel(input logic [5:0] x, input logic [5:0] y, input logic [11:0] c);
        expect_pixel(x, y, c);
        send(8'h01);
        send({2'b00, x});
        send({2'b00, y});
        send({4'h0, c[11:8]});
        send(c[7:0]);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 32'd0);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, bus.busy}, 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        n_vec            = 0;
        n_miss           = 0;
        prev_we          = 1'b0;
        resetn           = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_byte      = 8'h00;
        bus.rx_frame_end = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_write_en", {31'd0, bus.write_en}, 32'd0);
        check("rst_write_x",  {26'd0, bus.write_x}, 32'd0);
        check("rst_write_y",  {26'd0, bus.write_y}, 32'd0);
        check("rst_color",    {20'd0, bus.pixel_color}, 32'd0);
        check("rst_busy",     {31'd0, bus.busy}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("rst_bad_cmd",  {31'd0, bus.bad_cmd}, 32'd0);

        // Single PIXEL with exact latency: c_lo pushed, popped next edge,
        // write visible for the one cycle after that.
        expect_pixel(6'd5, 6'd10, 12'hF3C);
        send(8'h01); send(8'h05); send(8'h0A); send(8'h0F); send(8'h3C);
        @(negedge clk);
        check("pixel_latency_before", {31'd0, bus.write_en}, 32'd0);
        @(negedge clk);
        check("pixel_latency_strobe", {31'd0, bus.write_en}, 32'd1);
        @(negedge clk);
        check("pixel_latency_after", {31'd0, bus.write_en}, 32'd0);
        drain("drain_single_pixel", 50);

        // Masking of unused upper bits
        expect_pixel(6'd63, 6'd1, 12'h700);
        send(8'h01); send(8'hFF); send(8'hC1); send(8'hA7); send(8'h00);
        drain("drain_masking", 50);

        // FILL sweep with a PIXEL queued mid-sweep
        expect_sweep(12'h123);
        send(8'h03); send(8'h01); send(8'h23);
        wait_busy("fill_busy_rises");
        send_pixel(6'd5, 6'd6, 12'hABC);
        check("fill_still_busy", {31'd0, bus.busy}, 32'd1);
        drain("drain_fill", 6000);
        check("fill_busy_fell", {31'd0, bus.busy}, 32'd0);

        // Frame abort via separate marker
        send(8'h01); send(8'h05);
        drive(1'b0, 8'h00, 1'b1);
        expect_pixel(6'd2, 6'd3, 12'h0FF);
        send(8'h01); send(8'h02); send(8'h03); send(8'h00); send(8'hFF);
        drain("drain_abort_sep", 50);

        // Frame abort via coincident byte + marker
        send(8'h01);
        drive(1'b1, 8'h05, 1'b1);
        expect_pixel(6'd2, 6'd3, 12'h0FF);
        send(8'h01); send(8'h02); send(8'h03); send(8'h00); send(8'hFF);
        drain("drain_abort_coinc", 50);

        // Overflow: 64 bytes fit while CLEAR sweeps, 6 more are dropped
        expect_sweep(12'h000);
        send(8'h02);
        wait_busy("clear_busy_rises");
        for (int i = 0; i < 12; i++) begin
            send_pixel(6'(i + 10), 6'(i * 5), {4'(i), 8'(i * 17)});
        end
        repeat (4) send(8'h00);
        check("overflow_before_full", {31'd0, bus.overflow}, 32'd0);
        send(8'h01); send(8'h3F); send(8'h3F); send(8'h0F); send(8'hFF); send(8'h00);
        check("overflow_set", {31'd0, bus.overflow}, 32'd1);
        check("clear_still_busy", {31'd0, bus.busy}, 32'd1);
        drain("drain_overflow", 6000);
        check("overflow_sticky", {31'd0, bus.overflow}, 32'd1);

        // Bad opcode
        check("bad_cmd_clear", {31'd0, bus.bad_cmd}, 32'd0);
        send(8'h7E);
        repeat (3) @(negedge clk);
        check("bad_cmd_set", {31'd0, bus.bad_cmd}, 32'd1);

        // Reset mid-CLEAR with a partial packet still queued
        expect_sweep(12'h000);
        send(8'h02);
        wait_busy("reset_sweep_busy");
        send(8'h01); send(8'h07);
        repeat (50) @(negedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        sb.delete();
        #1;
        check("async_rst_write_en", {31'd0, bus.write_en}, 32'd0);
        check("async_rst_busy",     {31'd0, bus.busy}, 32'd0);
        check("async_rst_bad_cmd",  {31'd0, bus.bad_cmd}, 32'd0);
        check("async_rst_overflow", {31'd0, bus.overflow}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        expect_pixel(6'd8, 6'd9, 12'h011);
        send(8'h01); send(8'h08); send(8'h09); send(8'h00); send(8'h11);
        drain("drain_post_reset", 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
